// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - fetch-lookup and EX-resolution signal bundle for btb_predictor
interface btb_predictor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic [PC_W-1:0]  if_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic [1:0]       pred_state;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [PC_W-1:0]  ex_pred_target;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, pred_state, redirect, redirect_pc,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, pred_state, redirect, redirect_pc,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with 2-bit counters and EX-stage branch resolution
module btb_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  btb_predictor_if.slave  bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [1:0]         state_q  [ENTRIES];
  logic [1:0]         state_d  [ENTRIES];
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             br_mispred, alias_mispred, redirect;
  logic [1:0]       cur_state;

  assign if_idx = bus.if_pc[IDX_W-1:0];
  assign if_tag = bus.if_pc[PC_W-1:IDX_W];
  assign ex_idx = bus.ex_pc[IDX_W-1:0];
  assign ex_tag = bus.ex_pc[PC_W-1:IDX_W];

  assign if_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign cur_state = state_q[ex_idx];

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  always_comb begin
    bus.pred_taken  = if_hit & state_q[if_idx][1];
    bus.pred_target = if_hit ? target_q[if_idx] : bus.if_pc + PC_W'(1);
    bus.pred_state  = if_hit ? state_q[if_idx] : 2'b01;
  end

  always_comb begin
    br_mispred    = bus.ex_is_branch &
                    ((bus.ex_taken != bus.ex_pred_taken) |
                     (bus.ex_taken & bus.ex_pred_taken &
                      (bus.ex_target != bus.ex_pred_target)));
    alias_mispred = ~bus.ex_is_branch & bus.ex_pred_taken;
    redirect      = bus.ex_valid & (br_mispred | alias_mispred);
    bus.redirect    = redirect;
    bus.redirect_pc = (bus.ex_is_branch & bus.ex_taken) ? bus.ex_target
                                                        : bus.ex_pc + PC_W'(1);
  end

  // Training uses the live table entry, not the state carried down the pipe.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    state_d  = state_q;
    if (bus.ex_valid) begin
      if (bus.ex_is_branch) begin
        if (ex_hit) begin
          if (bus.ex_taken) begin
            state_d[ex_idx]  = (cur_state == 2'b11) ? 2'b11 : cur_state + 2'b01;
            target_d[ex_idx] = bus.ex_target;
          end else begin
            state_d[ex_idx]  = (cur_state == 2'b00) ? 2'b00 : cur_state - 2'b01;
          end
        end else if (bus.ex_taken) begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = bus.ex_target;
          state_d[ex_idx]  = 2'b10;
        end
      end else if (ex_hit) begin
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q + CNT_W'(bus.ex_valid & bus.ex_is_branch);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(redirect);
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        state_q[i]  <= 2'b00;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      state_q       <= state_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule
